rs: RTL and testbench
=====================

RS -- requirements
Module: rs

Interface
REQ-001 Parameter RS_SIZE, default 16, SHALL set the number of entries (power of two); RS_POS_WID = log2(RS_SIZE).
REQ-002 Widths SHALL come from setsize.v: ROB_POS_WID 4, OPCODE_WID 7, FUNCT3_WID 3, DATA_WID 32, ADDR_WID 32.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk only.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rdy  in  1  global enable; low SHALL freeze all state and outputs.
REQ-006 rollback  in  1  mispredict flush, synchronous.
REQ-007 issue  in  1  new instruction from decoder this cycle.
REQ-008 issue_rob_pos  in  ROB_POS_WID  destination ROB entry.
REQ-009 issue_opcode / issue_funct3 / issue_funct7  in  7/3/1  operation fields.
REQ-010 issue_rs1_val / issue_rs2_val  in  32  operand values, valid when matching dep flag is 0.
REQ-011 issue_rs1_dep / issue_rs2_dep  in  1  operand still pending.
REQ-012 issue_rs1_rob / issue_rs2_rob  in  ROB_POS_WID  producer tag of pending operand.
REQ-013 issue_imm  in  32;  issue_pc  in  32.
REQ-014 rs_nxt_full  out  1  combinational; decoder SHALL not assert issue the cycle after this is high.
REQ-015 alu_en  out  1  registered dispatch strobe to ALU.
REQ-016 alu_rob_pos, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc  out  registered  dispatched entry fields.
REQ-017 alu_result / alu_result_rob_pos / alu_result_val  in  1/4/32  ALU broadcast.
REQ-018 lsb_result / lsb_result_rob_pos / lsb_result_val  in  1/4/32  load/store buffer broadcast.

Function
REQ-019 Each entry SHALL hold busy, rob_pos, opcode, funct3, funct7, val1, val2, dep1, dep2, tag1, tag2, imm, pc.
REQ-020 Entry ready = busy & !dep1 & !dep2.
REQ-021 Free slot = lowest-index entry with busy=0; dispatch slot = lowest-index ready entry.
REQ-022 On issue (rdy=1), free slot SHALL be filled at the clock edge with busy=1.
REQ-023 Issue-cycle bypass: if issue_rsX_dep=1 and a broadcast this cycle matches issue_rsX_rob, entry SHALL store that value with depX=0.
REQ-024 Each cycle, every busy entry with depX=1 and tagX equal to an asserted broadcast rob_pos SHALL capture the value and clear depX; ALU and LSB broadcasts apply in the same cycle independently.
REQ-025 At most one dispatch per cycle: if any entry ready, alu_en<=1, alu_* <= entry fields, entry busy<=0 at the same edge; else alu_en<=0.
REQ-026 Readiness SHALL use registered state only: an entry filled or woken at edge N is dispatchable from edge N+1, so alu_en rises at edge N+1 at earliest (1-cycle issue-to-dispatch minimum).
REQ-027 Issue and dispatch in the same cycle SHALL both take effect; a dispatched slot SHALL not be reused as the free slot in that same cycle.
REQ-028 rs_nxt_full = (free count == 0) | (free count == 1 & issue), evaluated from current-cycle registers.
REQ-029 issue while no free entry is a protocol error; state SHALL remain unchanged and the instruction dropped.
REQ-030 Age ordering is not guaranteed; only lowest-index priority.
REQ-031 rdy=0 SHALL ignore issue and broadcasts and hold alu_en and alu_* unchanged.

Reset
REQ-032 rst or rollback (rdy ignored) SHALL clear all busy and dep bits and drive alu_en=0 and all alu_* outputs to 0 at the next edge; rst dominates rollback; issue that cycle SHALL be discarded.
REQ-033 After reset, rs_nxt_full=0 and all RS_SIZE entries free.

Verification
REQ-034 Issue ADD rob 3, deps 0, val1=5 val2=7 -> next edge alu_en=1, alu_rob_pos=3, alu_val1=5, alu_val2=7; following edge alu_en=0.
REQ-035 Issue rob 2, rs1_dep=1 tag 6; 3 cycles later alu_result=1 pos 6 val 0x10 -> alu_en=1 on the edge after broadcast with alu_val1=0x10.
REQ-036 Issue with rs2_dep tag 4 while lsb_result pos 4 val 0xAB same cycle -> entry stored ready, alu_en=1 next edge with alu_val2=0xAB.
REQ-037 Fill 16 entries all dependent on tag 9 -> rs_nxt_full=1 during 16th issue; broadcast tag 9 -> 16 consecutive alu_en pulses, index 0..15 order.
REQ-038 8 busy entries, assert rollback -> next edge alu_en=0, rs_nxt_full=0, later broadcasts cause no dispatch.
REQ-039 rdy=0 for 5 cycles with pending broadcast and issue -> no state change; alu_en held.

Source files
------------

// File: rtl/rs.sv
// Reservation station: holds issued instructions until both operands are
// available, captures ALU/LSB result broadcasts, and dispatches one ready entry per cycle.
module rs #(
    parameter int   RS_SIZE     = 16,
    localparam int  RS_POS_WID  = $clog2(RS_SIZE),
    localparam int  ROB_POS_WID = 4,
    localparam int  OPCODE_WID  = 7,
    localparam int  FUNCT3_WID  = 3,
    localparam int  DATA_WID    = 32,
    localparam int  ADDR_WID    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   rollback,

    input  logic                   issue,
    input  logic [ROB_POS_WID-1:0] issue_rob_pos,
    input  logic [OPCODE_WID-1:0]  issue_opcode,
    input  logic [FUNCT3_WID-1:0]  issue_funct3,
    input  logic                   issue_funct7,
    input  logic [DATA_WID-1:0]    issue_rs1_val,
    input  logic                   issue_rs1_dep,
    input  logic [ROB_POS_WID-1:0] issue_rs1_rob,
    input  logic [DATA_WID-1:0]    issue_rs2_val,
    input  logic                   issue_rs2_dep,
    input  logic [ROB_POS_WID-1:0] issue_rs2_rob,
    input  logic [DATA_WID-1:0]    issue_imm,
    input  logic [ADDR_WID-1:0]    issue_pc,

    output logic                   rs_nxt_full,

    output logic                   alu_en,
    output logic [ROB_POS_WID-1:0] alu_rob_pos,
    output logic [OPCODE_WID-1:0]  alu_opcode,
    output logic [FUNCT3_WID-1:0]  alu_funct3,
    output logic                   alu_funct7,
    output logic [DATA_WID-1:0]    alu_val1,
    output logic [DATA_WID-1:0]    alu_val2,
    output logic [DATA_WID-1:0]    alu_imm,
    output logic [ADDR_WID-1:0]    alu_pc,

    input  logic                   alu_result,
    input  logic [ROB_POS_WID-1:0] alu_result_rob_pos,
    input  logic [DATA_WID-1:0]    alu_result_val,
    input  logic                   lsb_result,
    input  logic [ROB_POS_WID-1:0] lsb_result_rob_pos,
    input  logic [DATA_WID-1:0]    lsb_result_val
);

    localparam int CNT_WID = RS_POS_WID + 1;

    typedef struct packed {
        logic                   busy;
        logic [ROB_POS_WID-1:0] rob_pos;
        logic [OPCODE_WID-1:0]  opcode;
        logic [FUNCT3_WID-1:0]  funct3;
        logic                   funct7;
        logic [DATA_WID-1:0]    val1;
        logic [DATA_WID-1:0]    val2;
        logic                   dep1;
        logic                   dep2;
        logic [ROB_POS_WID-1:0] tag1;
        logic [ROB_POS_WID-1:0] tag2;
        logic [DATA_WID-1:0]    imm;
        logic [ADDR_WID-1:0]    pc;
    } entry_t;

    // Returns {dep, val} after snooping both broadcast buses; ALU wins a tie.
    function automatic logic [DATA_WID:0] resolve(
        input logic                   dep,
        input logic [ROB_POS_WID-1:0] tag,
        input logic [DATA_WID-1:0]    val,
        input logic                   a_en,
        input logic [ROB_POS_WID-1:0] a_pos,
        input logic [DATA_WID-1:0]    a_val,
        input logic                   l_en,
        input logic [ROB_POS_WID-1:0] l_pos,
        input logic [DATA_WID-1:0]    l_val
    );
        resolve = {dep, val};
        if (dep && a_en && a_pos == tag)
            resolve = {1'b0, a_val};
        else if (dep && l_en && l_pos == tag)
            resolve = {1'b0, l_val};
    endfunction

    entry_t                ent [RS_SIZE];
    logic [RS_SIZE-1:0]    busy;
    logic [RS_SIZE-1:0]    ready;
    logic                  free_any;
    logic [RS_POS_WID-1:0] free_idx;
    logic                  disp_any;
    logic [RS_POS_WID-1:0] disp_idx;
    logic [CNT_WID-1:0]    free_cnt;
    logic                  issue_fire;
    logic [DATA_WID:0]     iss_op1;
    logic [DATA_WID:0]     iss_op2;
    entry_t                iss_ent;
    entry_t                disp_ent;

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        disp_any = 1'b0;
        disp_idx = '0;
        free_cnt = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_any = 1'b1;
                free_idx = i[RS_POS_WID-1:0];
            end
            if (ready[i]) begin
                disp_any = 1'b1;
                disp_idx = i[RS_POS_WID-1:0];
            end
            free_cnt = free_cnt + {{RS_POS_WID{1'b0}}, ~busy[i]};
        end
    end

    assign rs_nxt_full = (free_cnt == '0) || (free_cnt == CNT_WID'(1) && issue);
    assign issue_fire  = issue && free_any;

    assign iss_op1 = resolve(issue_rs1_dep, issue_rs1_rob, issue_rs1_val,
                             alu_result, alu_result_rob_pos, alu_result_val,
                             lsb_result, lsb_result_rob_pos, lsb_result_val);
    assign iss_op2 = resolve(issue_rs2_dep, issue_rs2_rob, issue_rs2_val,
                             alu_result, alu_result_rob_pos, alu_result_val,
                             lsb_result, lsb_result_rob_pos, lsb_result_val);

    always_comb begin
        iss_ent         = '0;
        iss_ent.busy    = 1'b1;
        iss_ent.rob_pos = issue_rob_pos;
        iss_ent.opcode  = issue_opcode;
        iss_ent.funct3  = issue_funct3;
        iss_ent.funct7  = issue_funct7;
        iss_ent.dep1    = iss_op1[DATA_WID];
        iss_ent.val1    = iss_op1[DATA_WID-1:0];
        iss_ent.dep2    = iss_op2[DATA_WID];
        iss_ent.val2    = iss_op2[DATA_WID-1:0];
        iss_ent.tag1    = issue_rs1_rob;
        iss_ent.tag2    = issue_rs2_rob;
        iss_ent.imm     = issue_imm;
        iss_ent.pc      = issue_pc;
    end

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ent
        entry_t            ent_reg;
        logic [DATA_WID:0] wake1;
        logic [DATA_WID:0] wake2;

        assign wake1 = resolve(ent_reg.dep1, ent_reg.tag1, ent_reg.val1,
                               alu_result, alu_result_rob_pos, alu_result_val,
                               lsb_result, lsb_result_rob_pos, lsb_result_val);
        assign wake2 = resolve(ent_reg.dep2, ent_reg.tag2, ent_reg.val2,
                               alu_result, alu_result_rob_pos, alu_result_val,
                               lsb_result, lsb_result_rob_pos, lsb_result_val);

        // A free slot is never the dispatch slot, so fill and dispatch cannot collide.
        always_ff @(posedge clk) begin
            if (rst || rollback) begin
                ent_reg <= '0;
            end else if (rdy) begin
                if (issue_fire && free_idx == RS_POS_WID'(gi)) begin
                    ent_reg <= iss_ent;
                end else if (ent_reg.busy) begin
                    if (disp_any && disp_idx == RS_POS_WID'(gi))
                        ent_reg.busy <= 1'b0;
                    {ent_reg.dep1, ent_reg.val1} <= wake1;
                    {ent_reg.dep2, ent_reg.val2} <= wake2;
                end
            end
        end

        assign ent[gi]   = ent_reg;
        assign busy[gi]  = ent_reg.busy;
        assign ready[gi] = ent_reg.busy & ~ent_reg.dep1 & ~ent_reg.dep2;
    end

    assign disp_ent = ent[disp_idx];

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            alu_en      <= 1'b0;
            alu_rob_pos <= '0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
        end else if (rdy) begin
            alu_en <= disp_any;
            if (disp_any) begin
                alu_rob_pos <= disp_ent.rob_pos;
                alu_opcode  <= disp_ent.opcode;
                alu_funct3  <= disp_ent.funct3;
                alu_funct7  <= disp_ent.funct7;
                alu_val1    <= disp_ent.val1;
                alu_val2    <= disp_ent.val2;
                alu_imm     <= disp_ent.imm;
                alu_pc      <= disp_ent.pc;
            end
        end
    end

endmodule

// File: tb/tb_rs.sv
// Directed bench for rs: expected dispatches are queued at issue time and
// compared by a monitor whenever alu_en pulses.
module tb_rs;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, issue;
    logic [3:0]  issue_rob_pos, issue_rs1_rob, issue_rs2_rob;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7, issue_rs1_dep, issue_rs2_dep;
    logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
    logic        rs_nxt_full, alu_en, alu_funct7;
    logic [3:0]  alu_rob_pos;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic        alu_result, lsb_result;
    logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
    logic [31:0] alu_result_val, lsb_result_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  rob;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [6:0]  op;
        logic [31:0] imm;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    rs #(.RS_SIZE(16)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue(issue), .issue_rob_pos(issue_rob_pos),
        .issue_opcode(issue_opcode), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_rs1_val(issue_rs1_val), .issue_rs1_dep(issue_rs1_dep), .issue_rs1_rob(issue_rs1_rob),
        .issue_rs2_val(issue_rs2_val), .issue_rs2_dep(issue_rs2_dep), .issue_rs2_rob(issue_rs2_rob),
        .issue_imm(issue_imm), .issue_pc(issue_pc),
        .rs_nxt_full(rs_nxt_full),
        .alu_en(alu_en), .alu_rob_pos(alu_rob_pos), .alu_opcode(alu_opcode),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
        .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        issue         = 1'b0;
        issue_rs1_dep = 1'b0;
        issue_rs2_dep = 1'b0;
        alu_result    = 1'b0;
        lsb_result    = 1'b0;
        rollback      = 1'b0;
    endtask

    task automatic drive_issue(input logic [3:0] rob, input logic [6:0] op,
                               input logic [31:0] v1, input logic [31:0] v2,
                               input logic d1, input logic [3:0] t1,
                               input logic d2, input logic [3:0] t2,
                               input logic [31:0] imm);
        issue         = 1'b1;
        issue_rob_pos = rob;
        issue_opcode  = op;
        issue_funct3  = 3'd0;
        issue_funct7  = 1'b0;
        issue_rs1_val = v1;
        issue_rs2_val = v2;
        issue_rs1_dep = d1;
        issue_rs1_rob = t1;
        issue_rs2_dep = d2;
        issue_rs2_rob = t2;
        issue_imm     = imm;
        issue_pc      = 32'h1000;
    endtask

    task automatic push(input logic [3:0] rob, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [6:0] op, input logic [31:0] imm);
        exp_t e;
        e.rob = rob; e.v1 = v1; e.v2 = v2; e.op = op; e.imm = imm;
        sbq.push_back(e);
    endtask

    // Dispatch monitor: only edges where the RS was enabled and not flushing produce a transaction.
    always @(posedge clk) begin
        logic s_ok;
        exp_t e;
        s_ok = rdy && !rst && !rollback;
        #1;
        if (s_ok && alu_en) begin
            if (sbq.size() == 0) begin
                check("unexpected_dispatch", {28'd0, alu_rob_pos}, 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                $display("dispatch rob=%0d val1=%0h val2=%0h op=%0h imm=%0h",
                         alu_rob_pos, alu_val1, alu_val2, alu_opcode, alu_imm);
                check("disp_rob", {28'd0, alu_rob_pos}, {28'd0, e.rob});
                check("disp_val1", alu_val1, e.v1);
                check("disp_val2", alu_val2, e.v2);
                check("disp_op", {25'd0, alu_opcode}, {25'd0, e.op});
                check("disp_imm", alu_imm, e.imm);
            end
        end
    end

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        issue_rob_pos = '0; issue_opcode = '0; issue_funct3 = '0; issue_funct7 = 1'b0;
        issue_rs1_val = '0; issue_rs2_val = '0; issue_rs1_rob = '0; issue_rs2_rob = '0;
        issue_imm = '0; issue_pc = '0;
        alu_result_rob_pos = '0; alu_result_val = '0;
        lsb_result_rob_pos = '0; lsb_result_val = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("rst_alu_en", {31'd0, alu_en}, 32'd0);
        check("rst_full", {31'd0, rs_nxt_full}, 32'd0);
        check("rst_rob_pos", {28'd0, alu_rob_pos}, 32'd0);
        check("rst_val1", alu_val1, 32'd0);

        // Independent operands: dispatch one edge after the fill edge.
        drive_issue(4'd3, 7'h33, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
        push(4'd3, 32'd5, 32'd7, 7'h33, 32'd0);
        #1 check("empty_full", {31'd0, rs_nxt_full}, 32'd0);
        tick(); idle();
        check("add_fill_en", {31'd0, alu_en}, 32'd0);
        tick();
        check("add_disp_en", {31'd0, alu_en}, 32'd1);
        tick();
        check("add_after_en", {31'd0, alu_en}, 32'd0);

        // Wake-up from ALU broadcast three cycles after issue.
        drive_issue(4'd2, 7'h33, 32'd0, 32'd3, 1'b1, 4'd6, 1'b0, 4'd0, 32'd0);
        push(4'd2, 32'h10, 32'd3, 7'h33, 32'd0);
        tick(); idle();
        tick(); tick();
        check("dep_wait_en", {31'd0, alu_en}, 32'd0);
        alu_result = 1'b1; alu_result_rob_pos = 4'd6; alu_result_val = 32'h10;
        tick(); idle();
        check("dep_wake_en", {31'd0, alu_en}, 32'd0);
        tick();
        check("dep_disp_en", {31'd0, alu_en}, 32'd1);
        tick();

        // Issue-cycle bypass from the LSB bus.
        drive_issue(4'd5, 7'h13, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 32'h20);
        lsb_result = 1'b1; lsb_result_rob_pos = 4'd4; lsb_result_val = 32'hAB;
        push(4'd5, 32'd1, 32'hAB, 7'h13, 32'h20);
        tick(); idle();
        check("byp_fill_en", {31'd0, alu_en}, 32'd0);
        tick();
        check("byp_disp_en", {31'd0, alu_en}, 32'd1);
        tick();

        // Back-to-back: second fill lands while the first dispatches.
        drive_issue(4'd7, 7'h33, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
        push(4'd7, 32'd1, 32'd2, 7'h33, 32'd0);
        tick();
        drive_issue(4'd8, 7'h33, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
        push(4'd8, 32'd3, 32'd4, 7'h33, 32'd0);
        tick(); idle();
        check("b2b_first_en", {31'd0, alu_en}, 32'd1);
        tick();
        check("b2b_second_en", {31'd0, alu_en}, 32'd1);
        tick();
        check("b2b_done_en", {31'd0, alu_en}, 32'd0);

        // Fill all 16 entries waiting on tag 9, then release them together.
        for (int i = 0; i < 16; i++) begin
            drive_issue(4'(i), 7'h33, 32'd0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0, 32'd0);
            push(4'(i), 32'h99, 32'(i), 7'h33, 32'd0);
            #1 check("fill_full", {31'd0, rs_nxt_full}, {31'd0, (i == 15)});
            tick();
        end
        idle();
        #1 check("full_hold", {31'd0, rs_nxt_full}, 32'd1);
        drive_issue(4'd7, 7'h33, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
        tick(); idle();
        tick();
        check("overflow_drop_en", {31'd0, alu_en}, 32'd0);
        check("overflow_full", {31'd0, rs_nxt_full}, 32'd1);
        alu_result = 1'b1; alu_result_rob_pos = 4'd9; alu_result_val = 32'h99;
        tick(); idle();
        check("drain_wake_en", {31'd0, alu_en}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("drain_en", {31'd0, alu_en}, 32'd1);
        end
        tick();
        check("drain_done_en", {31'd0, alu_en}, 32'd0);

        // Rollback with 8 dependent entries and a concurrent ready issue.
        for (int i = 0; i < 8; i++) begin
            drive_issue(4'(i), 7'h33, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 32'd0);
            tick();
        end
        rollback = 1'b1;
        drive_issue(4'd14, 7'h33, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
        tick(); idle();
        check("rb_en", {31'd0, alu_en}, 32'd0);
        check("rb_full", {31'd0, rs_nxt_full}, 32'd0);
        check("rb_rob_pos", {28'd0, alu_rob_pos}, 32'd0);
        alu_result = 1'b1; alu_result_rob_pos = 4'd12; alu_result_val = 32'd1;
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rb_nodisp_en", {31'd0, alu_en}, 32'd0);
        end

        // rdy low freezes state and the dispatch output.
        drive_issue(4'd11, 7'h33, 32'd0, 32'd6, 1'b1, 4'd1, 1'b0, 4'd0, 32'd0);
        tick();
        drive_issue(4'd10, 7'h33, 32'd4, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
        push(4'd10, 32'd4, 32'd4, 7'h33, 32'd0);
        tick(); idle();
        check("frz_fill_en", {31'd0, alu_en}, 32'd0);
        tick();
        check("frz_disp_en", {31'd0, alu_en}, 32'd1);
        rdy = 1'b0;
        alu_result = 1'b1; alu_result_rob_pos = 4'd1; alu_result_val = 32'h77;
        drive_issue(4'd13, 7'h33, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("frz_hold_en", {31'd0, alu_en}, 32'd1);
            check("frz_hold_rob", {28'd0, alu_rob_pos}, 32'd10);
        end
        rdy = 1'b1;
        idle();
        tick();
        check("frz_after_en", {31'd0, alu_en}, 32'd0);
        tick();
        check("frz_after2_en", {31'd0, alu_en}, 32'd0);
        alu_result = 1'b1; alu_result_rob_pos = 4'd1; alu_result_val = 32'h55;
        push(4'd11, 32'h55, 32'd6, 7'h33, 32'd0);
        tick(); idle();
        check("frz_wake_en", {31'd0, alu_en}, 32'd0);
        tick();
        check("frz_late_disp_en", {31'd0, alu_en}, 32'd1);
        tick();
        check("frz_end_en", {31'd0, alu_en}, 32'd0);

        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
